// File: rtl/buzzer_pattern_ctrl.sv
// Avalon-MM buzzer sequencer: timed ON/OFF bursts with repeat count and optional tone carrier.
// Define BUZZ_IRQ_EN to add the completion interrupt (irq port and pending flag).
module buzzer_pattern_ctrl #(
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned TONE_HALF = 125,
    parameter int unsigned TW        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port
`ifdef BUZZ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PW  = $clog2(PRESCALE);
    localparam int unsigned THW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] on_time_q, on_time_d;
    logic [TW-1:0] off_time_q, off_time_d;
    logic [7:0]    repeat_q, repeat_d;
    logic [7:0]    rep_cnt_q, rep_cnt_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [THW-1:0] tone_cnt_q, tone_cnt_d;
    logic          out_q, out_d;
    logic          done_q, done_d;

    logic wr, start, stop, tick, phase_end, tone_flip, enter_on, set_done, irq_bit;
    logic unused_wdata;

    assign unused_wdata = ^writedata[31:TW];

    assign wr        = chipselect & ~write_n;
    assign start     = wr && (address == 2'd0) && writedata[0];
    assign stop      = wr && (address == 2'd0) && writedata[1];
    assign tick      = (pre_cnt_q == PW'(PRESCALE - 1));
    // Treat a zero reload like one tick so a phase can never stall on a wrapped counter.
    assign phase_end = tick && (tick_cnt_q <= TW'(1));
    assign tone_flip = (TONE_HALF != 0) && (tone_cnt_q == THW'(TONE_HALF - 1));

    always_comb begin
        state_d    = state_q;
        on_time_d  = on_time_q;
        off_time_d = off_time_q;
        repeat_d   = repeat_q;
        rep_cnt_d  = rep_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        tick_cnt_d = tick_cnt_q;
        tone_cnt_d = tone_cnt_q;
        out_d      = out_q;
        done_d     = done_q;
        enter_on   = 1'b0;
        set_done   = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
        end else if (start && (on_time_q != '0)) begin
            enter_on  = 1'b1;
            rep_cnt_d = 8'd1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (phase_end) begin
                        if ((repeat_q != 8'd0) && (rep_cnt_q == repeat_q)) begin
                            state_d  = ST_IDLE;
                            out_d    = 1'b0;
                            done_d   = 1'b1;
                            set_done = 1'b1;
                        end else if (off_time_q == '0) begin
                            enter_on  = 1'b1;
                            rep_cnt_d = rep_cnt_q + 8'd1;
                        end else begin
                            state_d    = ST_OFF;
                            out_d      = 1'b0;
                            pre_cnt_d  = '0;
                            tick_cnt_d = off_time_q;
                        end
                    end else begin
                        pre_cnt_d  = tick ? '0 : pre_cnt_q + PW'(1);
                        tick_cnt_d = tick ? tick_cnt_q - TW'(1) : tick_cnt_q;
                        if (tone_flip) begin
                            out_d      = ~out_q;
                            tone_cnt_d = '0;
                        end else begin
                            tone_cnt_d = tone_cnt_q + THW'(1);
                        end
                    end
                end
                ST_OFF: begin
                    if (phase_end) begin
                        enter_on  = 1'b1;
                        rep_cnt_d = rep_cnt_q + 8'd1;
                    end else begin
                        pre_cnt_d  = tick ? '0 : pre_cnt_q + PW'(1);
                        tick_cnt_d = tick ? tick_cnt_q - TW'(1) : tick_cnt_q;
                    end
                end
                default: ;
            endcase
        end

        // Phase loads use the register values held before this edge's write lands.
        if (enter_on) begin
            state_d    = ST_ON;
            out_d      = 1'b1;
            pre_cnt_d  = '0;
            tick_cnt_d = on_time_q;
            tone_cnt_d = '0;
        end

        if (wr) begin
            case (address)
                2'd1:    on_time_d  = writedata[TW-1:0];
                2'd2:    off_time_d = writedata[TW-1:0];
                2'd3:    repeat_d   = writedata[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            on_time_q  <= '0;
            off_time_q <= '0;
            repeat_q   <= '0;
            rep_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            tick_cnt_q <= '0;
            tone_cnt_q <= '0;
            out_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            on_time_q  <= on_time_d;
            off_time_q <= off_time_d;
            repeat_q   <= repeat_d;
            rep_cnt_q  <= rep_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            out_q      <= out_d;
            done_q     <= done_d;
        end
    end

`ifdef BUZZ_IRQ_EN
    logic irq_pending_q, irq_pending_d;
    logic ack;

    assign ack = wr && (address == 2'd0) && writedata[2];

    // A completion in the same cycle as an ack wins.
    always_comb begin
        irq_pending_d = irq_pending_q;
        if (set_done) begin
            irq_pending_d = 1'b1;
        end else if (ack) begin
            irq_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending_q <= 1'b0;
        end else begin
            irq_pending_q <= irq_pending_d;
        end
    end

    assign irq     = irq_pending_q;
    assign irq_bit = irq_pending_q;
`else
    logic unused_set_done;
    assign unused_set_done = set_done;
    assign irq_bit         = 1'b0;
`endif

    assign out_port = out_q;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[2:0]    = {done_q, state_q != ST_IDLE, irq_bit};
            2'd1:    readdata[TW-1:0] = on_time_q;
            2'd2:    readdata[TW-1:0] = off_time_q;
            default: readdata[7:0]    = repeat_q;
        endcase
    end

endmodule

// File: tb/tb_buzzer_pattern_ctrl.sv
// Bench for buzzer_pattern_ctrl: two instances (steady and toned) checked every cycle against
// a clock-count model, plus directed waveform checks.
`timescale 1ns/100ps
module tb_buzzer_pattern_ctrl;

    localparam int P = 4;
`ifdef BUZZ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata0, readdata1;
    logic        out0, out1;
`ifdef BUZZ_IRQ_EN
    logic        irq0, irq1;
`endif

    always #5 clk = ~clk;

    buzzer_pattern_ctrl #(.PRESCALE(P), .TONE_HALF(0), .TW(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata0), .out_port(out0)
`ifdef BUZZ_IRQ_EN
        , .irq(irq0)
`endif
    );

    buzzer_pattern_ctrl #(.PRESCALE(P), .TONE_HALF(2), .TW(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata1), .out_port(out1)
`ifdef BUZZ_IRQ_EN
        , .irq(irq1)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=on 2=off, left = clocks remaining in phase, el = clocks into ON.
    typedef struct packed {
        int          phase;
        int          left;
        int          el;
        logic [7:0]  cnt;
        logic [15:0] on;
        logic [15:0] off;
        logic [7:0]  rep;
        logic        done;
        logic        irq;
    } model_t;

    model_t m;
    bit     chk_en = 1'b0;

    function automatic model_t model_next(input model_t c, input logic wr, input logic [1:0] a,
                                          input logic [31:0] d);
        model_t n = c;
        logic start = wr && a == 2'd0 && d[0];
        logic stop  = wr && a == 2'd0 && d[1];
        logic ack   = wr && a == 2'd0 && d[2];
        logic set_done = 1'b0;
        if (stop) begin
            n.phase = 0;
        end else if (start && c.on != 0) begin
            n.phase = 1; n.left = c.on * P; n.el = 0; n.cnt = 8'd1; n.done = 1'b0;
        end else if (c.phase == 1) begin
            if (c.left == 1) begin
                if (c.rep != 0 && c.cnt == c.rep) begin
                    n.phase = 0; n.done = 1'b1; set_done = 1'b1;
                end else if (c.off == 0) begin
                    n.left = c.on * P; n.el = 0; n.cnt = c.cnt + 8'd1;
                end else begin
                    n.phase = 2; n.left = c.off * P;
                end
            end else begin
                n.left = c.left - 1; n.el = c.el + 1;
            end
        end else if (c.phase == 2) begin
            if (c.left == 1) begin
                n.phase = 1; n.left = c.on * P; n.el = 0; n.cnt = c.cnt + 8'd1;
            end else begin
                n.left = c.left - 1;
            end
        end
        if (set_done) n.irq = 1'b1;
        else if (ack) n.irq = 1'b0;
        if (wr) begin
            case (a)
                2'd1: n.on  = d[15:0];
                2'd2: n.off = d[15:0];
                2'd3: n.rep = d[7:0];
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic logic exp_out(input model_t s, input int th);
        if (s.phase != 1) return 1'b0;
        if (th == 0) return 1'b1;
        return ((s.el / th) % 2) == 0;
    endfunction

    function automatic logic [31:0] exp_rd(input model_t s, input logic [1:0] a);
        case (a)
            2'd0:    return {29'b0, s.done, s.phase != 0, s.irq & IRQ_ON};
            2'd1:    return {16'b0, s.on};
            2'd2:    return {16'b0, s.off};
            default: return {24'b0, s.rep};
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else m <= model_next(m, chipselect & ~write_n, address, writedata);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model out steady", {31'b0, out0}, {31'b0, exp_out(m, 0)});
            check("model out tone", {31'b0, out1}, {31'b0, exp_out(m, 2)});
            check("model readdata", readdata0, exp_rd(m, address));
            check("model readdata tone", readdata1, exp_rd(m, address));
`ifdef BUZZ_IRQ_EN
            check("model irq", {31'b0, irq0}, {31'b0, m.irq});
            check("model irq tone", {31'b0, irq1}, {31'b0, m.irq});
`endif
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0] tone_pat;
        tone_pat = 10'b1100110000;
        chk_en = 1'b1;

        // Reset state, then after release
        step();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); step();
            check("reset readdata", readdata0, 32'h0);
        end
        check("reset out_port", {31'b0, out0}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); step();
            check("post-reset readdata", readdata0, 32'h0);
        end

        // ON=3 OFF=2 REPEAT=2, steady
        wr(2'd1, 32'd3); wr(2'd2, 32'd2); wr(2'd3, 32'd2); wr(2'd0, 32'h1);
        for (int k = 1; k <= 40; k++) begin
            check("burst pattern", {31'b0, out0},
                  {31'b0, (k <= 12) || (k >= 21 && k <= 32)});
            if (k == 32) check("busy while on", readdata0, 32'h2);
            if (k == 33) check("done at end", readdata0, {29'b0, 1'b1, 1'b0, IRQ_ON});
            step();
        end
`ifdef BUZZ_IRQ_EN
        wr(2'd0, 32'h4);
        check("irq ack", {31'b0, irq0}, 32'h0);
`endif

        // Infinite repeat, then STOP mid-ON
        wr(2'd3, 32'd0); wr(2'd0, 32'h1);
        for (int k = 1; k <= 45; k++) begin
            check("forever pattern", {31'b0, out0}, {31'b0, ((k - 1) % 20) < 12});
            step();
        end
        wr(2'd0, 32'h2);
        check("stop out_port", {31'b0, out0}, 32'h0);
        check("stop status", readdata0, 32'h0);

        // Tone carrier, ON=2 REPEAT=1
        wr(2'd1, 32'd2); wr(2'd3, 32'd1); wr(2'd0, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            check("tone pattern", {31'b0, out1}, {31'b0, tone_pat[10 - k]});
            step();
        end

        // START with ON_TIME=0 ignored; STOP+START stays idle
        wr(2'd1, 32'd0); wr(2'd0, 32'h1); step();
        check("on0 start ignored busy", {31'b0, readdata0[1]}, 32'h0);
        wr(2'd1, 32'd1); wr(2'd0, 32'h3); step();
        check("stop+start busy", {31'b0, readdata0[1]}, 32'h0);
        check("stop+start out", {31'b0, out0}, 32'h0);

        // OFF=0 REPEAT=3 ON=1: continuous 12 clocks
        wr(2'd2, 32'd0); wr(2'd3, 32'd3); wr(2'd0, 32'h1);
        for (int k = 1; k <= 14; k++) begin
            check("gapless pattern", {31'b0, out0}, {31'b0, k <= 12});
            if (k == 13) check("gapless done", readdata0, {29'b0, 1'b1, 1'b0, IRQ_ON});
            step();
        end
`ifdef BUZZ_IRQ_EN
        check("irq after completion", {31'b0, irq0}, 32'h1);
`endif

        // Asynchronous reset mid-ON
        wr(2'd1, 32'd3); wr(2'd0, 32'h1);
        repeat (4) step();
        check("on before reset", {31'b0, out0}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset out_port", {31'b0, out0}, 32'h0);
`ifdef BUZZ_IRQ_EN
        check("async reset irq", {31'b0, irq0}, 32'h0);
`endif
        step();
        reset_n = 1'b1;

        // Completion after reset, then ack
        wr(2'd1, 32'd1); wr(2'd3, 32'd1); wr(2'd0, 32'h1);
        repeat (5) step();
        check("short done", readdata0, {29'b0, 1'b1, 1'b0, IRQ_ON});
`ifdef BUZZ_IRQ_EN
        check("short irq", {31'b0, irq0}, 32'h1);
        wr(2'd0, 32'h4);
        check("short irq ack", {31'b0, irq0}, 32'h0);
`endif
        repeat (3) step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
